pc_fetch_ctrl: RTL

//  Fetch sequencer that drives the PC register (PC_Next/en inputs) and the instruction-memory request port.

---
 rtl/pc_fetch_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/pc_fetch_ctrl.sv
//==============================================================================
// Module      : pc_fetch_ctrl
// Description : Fetch sequencer. It picks the next PC and drives the instruction
//               memory request. It also holds the fetched word for decode.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC  = 32'h0000_0100,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic [31:0] pc_next,
  output logic        pc_en,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        trap,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        if_ready,
  output logic        fetch_err
);

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_REQ   = 3'd1,
    S_OUT   = 3'd2,
    S_FLUSH = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  localparam logic [7:0] c_timeout = 8'(TIMEOUT);

  state_t      r_state;
  logic        r_imem_req;
  logic [31:0] r_imem_addr;
  logic        r_if_valid;
  logic [31:0] r_if_instr;
  logic [31:0] r_if_pc;
  logic        r_fetch_err;
  logic [7:0]  r_wait;

  logic        w_redirect;
  logic        w_advance;
  logic [31:0] w_target_raw;
  logic [31:0] w_target;
  logic [7:0]  w_wait_inc;
  logic        w_timeout;

  assign w_redirect   = !rst && (trap || branch_taken) &&
                        (r_state == S_REQ || r_state == S_OUT || r_state == S_FLUSH);
  assign w_advance    = !rst && (r_state == S_OUT) && if_ready && !stall;
  assign w_target_raw = trap ? TRAP_VEC : branch_target;
  assign w_target     = {w_target_raw[31:2], 2'b00};
  assign w_wait_inc   = r_wait + 8'd1;
  // A request stays high only in REQ/FLUSH, so this cannot fire in other states.
  assign w_timeout    = r_imem_req && !imem_ack && (w_wait_inc == c_timeout);

  always_comb begin
    pc_en   = 1'b0;
    pc_next = '0;
    if (!rst) begin
      if (r_state == S_BOOT) begin
        pc_en   = 1'b1;
        pc_next = RESET_VEC;
      end else if (w_redirect) begin
        pc_en   = 1'b1;
        pc_next = w_target;
      end else if (w_advance) begin
        pc_en   = 1'b1;
        pc_next = pc + 32'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_BOOT;
      r_imem_req  <= 1'b0;
      r_imem_addr <= '0;
      r_if_valid  <= 1'b0;
      r_if_instr  <= '0;
      r_if_pc     <= '0;
      r_fetch_err <= 1'b0;
      r_wait      <= '0;
    end else if (w_timeout) begin
      r_state     <= S_ERR;
      r_fetch_err <= 1'b1;
      r_imem_req  <= 1'b0;
      r_imem_addr <= '0;
      r_if_valid  <= 1'b0;
      r_if_instr  <= '0;
      r_if_pc     <= '0;
      r_wait      <= '0;
    end else begin
      case (r_state)
        S_BOOT: r_state <= S_REQ;

        S_REQ: begin
          if (!r_imem_req) begin
            // Entry cycle. A redirect here stays in REQ so the new PC is latched next cycle.
            if (!w_redirect) begin
              r_imem_addr <= pc;
              r_imem_req  <= 1'b1;
            end
          end else if (imem_ack) begin
            r_imem_req <= 1'b0;
            r_wait     <= '0;
            if (!w_redirect) begin
              r_if_instr <= imem_rdata;
              r_if_pc    <= r_imem_addr;
              r_if_valid <= 1'b1;
              r_state    <= S_OUT;
            end
          end else begin
            r_wait <= w_wait_inc;
            if (w_redirect) r_state <= S_FLUSH;
          end
        end

        S_OUT: begin
          if (w_redirect || w_advance) begin
            r_if_valid <= 1'b0;
            r_state    <= S_REQ;
          end
        end

        S_FLUSH: begin
          if (imem_ack) begin
            r_imem_req <= 1'b0;
            r_wait     <= '0;
            r_state    <= S_REQ;
          end else begin
            r_wait <= w_wait_inc;
          end
        end

        S_ERR:   r_state <= S_ERR;
        default: r_state <= S_ERR;
      endcase
    end
  end

  assign imem_req  = r_imem_req;
  assign imem_addr = r_imem_addr;
  assign if_valid  = r_if_valid;
  assign if_instr  = r_if_instr;
  assign if_pc     = r_if_pc;
  assign fetch_err = r_fetch_err;

endmodule

`default_nettype wire
